// File: rtl/daq_header_node.sv
// daq_header_node: tags accepted stream words with BCID and a wrapped readout
// window, queues them in a first-word-fall-through FIFO popped by the builder.
//
// Ports:
//   clk320               system clock, rising edge
//   rst                  asynchronous active-high reset
//   mngt_en              node enable; stream words are discarded when low
//   mngt_win_lower       window offset below the event BCID
//   mngt_win_width       window width in BCs
//   stream_valid         single-cycle qualifier for stream_data/stream_bcid
//   stream_data          stream payload
//   stream_bcid          BCID of the stream word
//   bconv_rd_strb        one-cycle pop strobe from the builder
//   hdr_valid            FIFO not empty; head entry is on hdr_*
//   hdr_data/bcid        head entry payload and BCID
//   hdr_win_start/end    head entry readout window
//   hdr_full             FIFO full
//   hdr_overflow         sticky: a header was lost to a full FIFO
//   hdr_drop_cnt         saturating count of full-FIFO losses
//                        (only with DAQ_HNODE_DROP_CNT_EN defined)
module daq_header_node #(
    parameter int DATA_W   = 32,
    parameter int BCID_W   = 12,
    parameter int BCID_MAX = 3564,
    parameter int DEPTH    = 8
) (
    input  logic              clk320,
    input  logic              rst,
    input  logic              mngt_en,
    input  logic [BCID_W-1:0] mngt_win_lower,
    input  logic [BCID_W-1:0] mngt_win_width,
    input  logic              stream_valid,
    input  logic [DATA_W-1:0] stream_data,
    input  logic [BCID_W-1:0] stream_bcid,
    input  logic              bconv_rd_strb,
    output logic              hdr_valid,
    output logic [DATA_W-1:0] hdr_data,
    output logic [BCID_W-1:0] hdr_bcid,
    output logic [BCID_W-1:0] hdr_win_start,
    output logic [BCID_W-1:0] hdr_win_end,
    output logic              hdr_full,
    output logic              hdr_overflow
`ifdef DAQ_HNODE_DROP_CNT_EN
    ,
    output logic [15:0]       hdr_drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 3 * BCID_W;
    localparam logic [BCID_W:0] MAX_X = (BCID_W + 1)'(BCID_MAX);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     head_q, head_d, in_w;
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              accept, pop, push, drop, full;
    logic [BCID_W:0]   bcid_x, low_x, wid_x, start_x, sum_x, end_x;

    // Window arithmetic is done one bit wider so the modular add/sub cannot overflow.
    always_comb begin
        bcid_x  = {1'b0, stream_bcid};
        low_x   = {1'b0, mngt_win_lower};
        wid_x   = {1'b0, mngt_win_width};
        start_x = (bcid_x >= low_x) ? bcid_x - low_x : bcid_x + MAX_X - low_x;
        sum_x   = start_x + wid_x;
        end_x   = (sum_x >= MAX_X) ? sum_x - MAX_X : sum_x;
        in_w    = {stream_data, stream_bcid, start_x[BCID_W-1:0], end_x[BCID_W-1:0]};
    end

    always_comb begin
        full   = cnt_q == FULL_CNT;
        accept = stream_valid & mngt_en;
        pop    = bconv_rd_strb & (cnt_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push   = accept & (~full | pop);
        drop   = accept & full & ~pop;
        cnt_d  = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        rd_d   = rd_q + AW'(pop);
        wr_d   = wr_q + AW'(push);
        ovf_d  = ovf_q | drop;
        // Head register tracks the entry at rd_d; bypass the incoming word when
        // it lands in an otherwise empty FIFO, hold the last value when empty.
        head_d = (cnt_d == '0) ? head_q : (cnt_q == (AW + 1)'(pop)) ? in_w : mem_q[rd_d];
    end

    always_ff @(posedge clk320) begin
        if (push) mem_q[wr_q] <= in_w;
    end

    always_ff @(posedge clk320 or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            head_q <= head_d;
        end
    end

`ifdef DAQ_HNODE_DROP_CNT_EN
    logic [15:0] dcnt_q;
    always_ff @(posedge clk320 or posedge rst) begin
        if (rst) dcnt_q <= '0;
        else if (drop && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 16'd1;
    end
    assign hdr_drop_cnt = dcnt_q;
`endif

    assign hdr_valid    = cnt_q != '0;
    assign hdr_full     = full;
    assign hdr_overflow = ovf_q;
    assign {hdr_data, hdr_bcid, hdr_win_start, hdr_win_end} = head_q;
endmodule

// File: tb/tb_daq_header_node.sv
// tb_daq_header_node: scoreboard bench for daq_header_node with directed vectors.
module tb_daq_header_node;
    logic        clk320 = 1'b0;
    logic        rst = 1'b1;
    logic        mngt_en = 1'b0;
    logic [11:0] mngt_win_lower = '0;
    logic [11:0] mngt_win_width = '0;
    logic        stream_valid = 1'b0;
    logic [31:0] stream_data = '0;
    logic [11:0] stream_bcid = '0;
    logic        bconv_rd_strb = 1'b0;
    logic        hdr_valid, hdr_full, hdr_overflow;
    logic [31:0] hdr_data;
    logic [11:0] hdr_bcid, hdr_win_start, hdr_win_end;
`ifdef DAQ_HNODE_DROP_CNT_EN
    logic [15:0] hdr_drop_cnt;
`endif

    daq_header_node dut (
        .clk320(clk320), .rst(rst), .mngt_en(mngt_en),
        .mngt_win_lower(mngt_win_lower), .mngt_win_width(mngt_win_width),
        .stream_valid(stream_valid), .stream_data(stream_data), .stream_bcid(stream_bcid),
        .bconv_rd_strb(bconv_rd_strb), .hdr_valid(hdr_valid), .hdr_data(hdr_data),
        .hdr_bcid(hdr_bcid), .hdr_win_start(hdr_win_start), .hdr_win_end(hdr_win_end),
        .hdr_full(hdr_full), .hdr_overflow(hdr_overflow)
`ifdef DAQ_HNODE_DROP_CNT_EN
        , .hdr_drop_cnt(hdr_drop_cnt)
`endif
    );

    always #5 clk320 = ~clk320;

    typedef struct {
        logic [31:0] d;
        logic [11:0] b, s, e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every effective pop is checked against the oldest expected header.
    always @(negedge clk320) begin
        if (!rst && bconv_rd_strb && hdr_valid) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pop_data", hdr_data, mon_e.d);
                chk("pop_bcid", hdr_bcid, mon_e.b);
                chk("pop_win_start", hdr_win_start, mon_e.s);
                chk("pop_win_end", hdr_win_end, mon_e.e);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [11:0] b, input logic [11:0] lo,
                        input logic [11:0] wd, input logic en, input logic [11:0] s,
                        input logic [11:0] e, input logic keep, input logic with_pop);
        @(posedge clk320);
        #1;
        mngt_en = en;
        mngt_win_lower = lo;
        mngt_win_width = wd;
        stream_data = d;
        stream_bcid = b;
        stream_valid = 1'b1;
        bconv_rd_strb = with_pop;
        if (keep) sb.push_back('{d: d, b: b, s: s, e: e});
        @(posedge clk320);
        #1;
        stream_valid = 1'b0;
        bconv_rd_strb = 1'b0;
        #2;
    endtask

    task automatic pop();
        @(posedge clk320);
        #1;
        bconv_rd_strb = 1'b1;
        @(posedge clk320);
        #1;
        bconv_rd_strb = 1'b0;
        #2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, hdr_valid, 0);
        chk({tag, "_full"}, hdr_full, 0);
        chk({tag, "_ovf"}, hdr_overflow, 0);
        chk({tag, "_data"}, hdr_data, 0);
        chk({tag, "_bcid"}, hdr_bcid, 0);
        chk({tag, "_ws"}, hdr_win_start, 0);
        chk({tag, "_we"}, hdr_win_end, 0);
    endtask

    initial begin
        repeat (10) @(posedge clk320);
        #3;
        chk_zero("reset");
        @(posedge clk320);
        #1;
        rst = 1'b0;
        #2;

        send(32'd11, 12'd0, 12'd0, 12'd0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
        chk("dis_valid", hdr_valid, 0);
        chk("dis_ovf", hdr_overflow, 0);

        send(32'd33, 12'd0, 12'd0, 12'd0, 1'b1, 12'd0, 12'd0, 1'b1, 1'b0);
        chk("cap_valid", hdr_valid, 1);
        chk("cap_data", hdr_data, 33);
        chk("cap_ws", hdr_win_start, 0);
        chk("cap_we", hdr_win_end, 0);
        pop();
        chk("cap_popped", hdr_valid, 0);

        send(32'hA5, 12'd5, 12'd10, 12'd20, 1'b1, 12'd3559, 12'd15, 1'b1, 1'b0);
        chk("wrap1_ws", hdr_win_start, 3559);
        chk("wrap1_we", hdr_win_end, 15);
        pop();
        send(32'hB6, 12'd3560, 12'd0, 12'd10, 1'b1, 12'd3560, 12'd6, 1'b1, 1'b0);
        chk("wrap2_ws", hdr_win_start, 3560);
        chk("wrap2_we", hdr_win_end, 6);
        pop();

        for (int i = 1; i <= 3; i++)
            send(32'(i), 12'(99 + i), 12'd0, 12'd0, 1'b1, 12'(99 + i), 12'(99 + i), 1'b1, 1'b0);
        chk("ord_head", hdr_data, 1);
        repeat (3) pop();
        chk("ord_empty", hdr_valid, 0);
        pop();
        chk("empty_strobe_valid", hdr_valid, 0);
        chk("empty_hold_data", hdr_data, 3);

        for (int i = 0; i <= 8; i++)
            send(32'h100 + 32'(i), 12'(i), 12'd0, 12'd5, 1'b1, 12'(i), 12'(i + 5), i < 8, 1'b0);
        chk("full_flag", hdr_full, 1);
        chk("full_ovf", hdr_overflow, 1);
        chk("full_head", hdr_data, 32'h100);
`ifdef DAQ_HNODE_DROP_CNT_EN
        chk("drop_cnt", hdr_drop_cnt, 1);
`endif
        send(32'h200, 12'd50, 12'd0, 12'd5, 1'b1, 12'd50, 12'd55, 1'b1, 1'b1);
        chk("pushpop_full", hdr_full, 1);
        chk("pushpop_head", hdr_data, 32'h101);
`ifdef DAQ_HNODE_DROP_CNT_EN
        chk("pushpop_drop_cnt", hdr_drop_cnt, 1);
`endif
        repeat (8) pop();
        chk("drain_valid", hdr_valid, 0);
        chk("drain_full", hdr_full, 0);
        chk("ovf_sticky", hdr_overflow, 1);

        for (int i = 0; i < 4; i++)
            send(32'h300 + 32'(i), 12'(i), 12'd0, 12'd0, 1'b1, 12'(i), 12'(i), 1'b0, 1'b0);
        chk("pre_rst_valid", hdr_valid, 1);
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
`ifdef DAQ_HNODE_DROP_CNT_EN
        chk("rst_drop_cnt", hdr_drop_cnt, 0);
`endif
        repeat (2) @(posedge clk320);
        #1;
        rst = 1'b0;
        #2;
        chk("post_rst_valid", hdr_valid, 0);
        pop();
        chk("post_rst_pop_valid", hdr_valid, 0);
        chk("post_rst_data", hdr_data, 0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
